// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: elastic MEM/WB pipeline register with a two-slot skid buffer.
// The main slot drives the wb_* outputs. The skid slot catches an entry that
// arrives while the main slot is stalled.
// mem_ready depends only on registered state, so there is no combinational
// path from wb_ready to mem_ready.
// Optional feature macro: MEM_WB_HILO_EN adds the HI/LO write request to the
// carried payload.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_WB_HILO_EN
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
`endif
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
`ifdef MEM_WB_HILO_EN
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
`endif
    output logic [CNT_W-1:0]  retire_cnt
);

`ifdef MEM_WB_HILO_EN
    localparam int PW = ADDR_W + 1 + DATA_W + 1 + 2 * DATA_W;
`else
    localparam int PW = ADDR_W + 1 + DATA_W;
`endif

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [PW-1:0]     r_main_pl;
    logic [PW-1:0]     r_skid_pl;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic [PW-1:0]     w_in_pl;
    logic              w_accept;
    logic              w_consume;
    logic              w_main_free;

`ifdef MEM_WB_HILO_EN
    assign w_in_pl = {mem_whilo, mem_hi, mem_lo, mem_wd, mem_wreg, mem_wdata};
    assign {wb_whilo, wb_hi, wb_lo, wb_wd, wb_wreg, wb_wdata} = r_main_pl;
`else
    assign w_in_pl = {mem_wd, mem_wreg, mem_wdata};
    assign {wb_wd, wb_wreg, wb_wdata} = r_main_pl;
`endif

    assign mem_ready   = !r_skid_valid;
    assign wb_valid    = r_main_valid;
    assign retire_cnt  = r_retire_cnt;
    assign w_accept    = mem_valid && !r_skid_valid;
    assign w_consume   = r_main_valid && wb_ready;
    // Main slot can take new content this cycle (empty or being drained).
    assign w_main_free = !r_main_valid || w_consume;

    // Slot state: skid has priority into main so ordering is preserved; an
    // emptied slot is zeroed so wb_wreg can never be 1 without wb_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pl    <= '0;
            r_skid_pl    <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pl    <= '0;
            r_skid_pl    <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_pl    <= r_skid_pl;
                r_skid_valid <= 1'b0;
                r_skid_pl    <= '0;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_pl    <= w_in_pl;
            end else begin
                r_main_valid <= 1'b0;
                r_main_pl    <= '0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_pl    <= w_in_pl;
        end
    end

    // Retired-write counter: counts consumed register writes, survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (!flush && w_consume && wb_wreg) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: random and directed stimulus against a queue-based model.
// The optional HI/LO checks are built when MEM_WB_HILO_EN is defined.
module tb_mem_wb_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_wd = '0;
    logic              mem_wreg = 1'b0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic              mem_whilo = 1'b0;
    logic [DATA_W-1:0] mem_hi = '0;
    logic [DATA_W-1:0] mem_lo = '0;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic [CNT_W-1:0]  retire_cnt;

`ifndef MEM_WB_HILO_EN
    assign wb_whilo = 1'b0;
    assign wb_hi    = '0;
    assign wb_lo    = '0;
`endif

    mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
`ifdef MEM_WB_HILO_EN
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
`endif
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
`ifdef MEM_WB_HILO_EN
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
`endif
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: the block is a FIFO of depth 2 whose head is what wb_* shows.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            bit cons, acc;
            ent_t e;
            cons = (q.size() > 0) && wb_ready;
            acc  = mem_valid && (q.size() < 2);
            if (cons) begin
                if (q[0].wreg) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                void'(q.pop_front());
            end
            if (acc) begin
                e.wd = mem_wd; e.wreg = mem_wreg; e.wdata = mem_wdata;
`ifdef MEM_WB_HILO_EN
                e.whilo = mem_whilo; e.hi = mem_hi; e.lo = mem_lo;
`else
                e.whilo = 1'b0; e.hi = '0; e.lo = '0;
`endif
                q.push_back(e);
            end
        end
    end

    // Compare process: every falling edge, DUT versus model.
    always @(negedge clk) begin
        ent_t h;
        if (q.size() > 0) h = q[0];
        else begin
            h.wd = '0; h.wreg = 1'b0; h.wdata = '0; h.whilo = 1'b0; h.hi = '0; h.lo = '0;
        end
        chk("wb_valid",   wb_valid,   q.size() > 0);
        chk("mem_ready",  mem_ready,  q.size() < 2);
        chk("wb_wd",      wb_wd,      h.wd);
        chk("wb_wreg",    wb_wreg,    h.wreg);
        chk("wb_wdata",   wb_wdata,   h.wdata);
        chk("wb_whilo",   wb_whilo,   h.whilo);
        chk("wb_hi",      wb_hi,      h.hi);
        chk("wb_lo",      wb_lo,      h.lo);
        chk("retire_cnt", retire_cnt, m_cnt);
    end

    // Drive one cycle of inputs (called at posedge+1) and advance past the edge.
    task automatic cyc(input bit v, input int wd, input bit wreg, input int wdata,
                       input bit rdy, input bit fl);
        mem_valid = v; mem_wd = wd[ADDR_W-1:0]; mem_wreg = wreg;
        mem_wdata = wdata; wb_ready = rdy; flush = fl;
        mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int saved;
        do_reset();
        chk("reset wb_valid", wb_valid, 0);
        chk("reset mem_ready", mem_ready, 1);
        chk("reset retire_cnt", retire_cnt, 0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, i, 1, 32'h100 + i, 1, 0);
            chk("stream wd", wb_wd, i);
            chk("stream wdata", wb_wdata, 32'h100 + i);
            chk("stream valid", wb_valid, 1);
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("stream cnt", retire_cnt, 8);
        chk("stream drained", wb_valid, 0);

        // Back-pressure fills the skid slot.
        cyc(1, 3, 1, 32'hA, 0, 0);
        chk("bp A ready", mem_ready, 1);
        cyc(1, 4, 1, 32'hB, 0, 0);
        chk("bp full ready", mem_ready, 0);
        chk("bp head A", wb_wd, 3);
        cyc(1, 7, 1, 32'hC, 0, 0);
        chk("bp hold A", wb_wd, 3);
        cyc(0, 0, 0, 0, 1, 0);
        chk("bp head B", wb_wd, 4);
        chk("bp ready back", mem_ready, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("bp empty", wb_valid, 0);
        chk("bp cnt", retire_cnt, 10);

        // Flush with both slots occupied and an incoming entry.
        cyc(1, 5, 1, 1, 0, 0);
        cyc(1, 6, 1, 2, 0, 0);
        saved = retire_cnt;
        cyc(1, 9, 1, 3, 1, 1);
        chk("flush valid", wb_valid, 0);
        chk("flush wreg", wb_wreg, 0);
        chk("flush ready", mem_ready, 1);
        chk("flush cnt", retire_cnt, saved);

        // Counter wrap: 17 counted writes + 3 uncounted from zero -> 1.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, i, i < 17, i, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("wrap cnt", retire_cnt, 1);

`ifdef MEM_WB_HILO_EN
        // HI/LO payload through the skid slot.
        cyc(1, 2, 1, 32'h22, 0, 0);
        mem_valid = 1; mem_wd = 9; mem_wreg = 1; mem_wdata = 32'h99;
        mem_whilo = 1; mem_hi = 32'hDEAD; mem_lo = 32'hBEEF; wb_ready = 0; flush = 0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 1, 0);
        chk("hilo wd", wb_wd, 9);
        chk("hilo whilo", wb_whilo, 1);
        chk("hilo hi", wb_hi, 32'hDEAD);
        chk("hilo lo", wb_lo, 32'hBEEF);
        cyc(0, 0, 0, 0, 1, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_wd    = ADDR_W'($urandom_range(0, 31));
            mem_wreg  = $urandom_range(0, 1) == 1;
            mem_wdata = $urandom;
            mem_whilo = $urandom_range(0, 1) == 1;
            mem_hi    = $urandom;
            mem_lo    = $urandom;
            wb_ready  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-stream with both slots full.
        cyc(1, 11, 1, 1, 0, 0);
        cyc(1, 12, 1, 2, 0, 0);
        chk("pre-reset full", mem_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst valid", wb_valid, 0);
        chk("async rst ready", mem_ready, 1);
        chk("async rst wd", wb_wd, 0);
        chk("async rst cnt", retire_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
